// File: rtl/im_boot_loader.sv
// Boot loader: receives a counted, XOR-checksummed byte image and writes it into
// instruction memory as little-endian words. The processor stays in reset until the image verifies.
module im_boot_loader #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              reload,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [DATA_W-1:0] im_din,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t              r_state;
   logic [7:0]          r_count;
   logic [7:0]          r_csum;
   logic [7:0]          r_word_idx;
   logic [1:0]          r_byte_idx;
   logic [DATA_W-1:0]   r_word;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_din;
   logic                r_cpu_rst;
   logic                r_done;
   logic                r_err;

   logic                w_ready;
   logic                w_xfer;
   logic [DATA_W-1:0]   w_word;
   logic [7:0]          w_word_next;
   logic                w_too_big;

   always_comb begin
      w_ready     = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_CHECK);
      w_xfer      = s_valid && w_ready;
      w_word_next = r_word_idx + 8'd1;
      w_too_big   = ({24'd0, s_data} > 32'(DEPTH));
      // Incoming byte merged into its lane so the completed word is available in the same cycle.
      w_word = r_word;
      case (r_byte_idx)
         2'd0:    w_word[7:0]   = s_data;
         2'd1:    w_word[15:8]  = s_data;
         2'd2:    w_word[23:16] = s_data;
         default: w_word[31:24] = s_data;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_count    <= '0;
         r_csum     <= '0;
         r_word_idx <= '0;
         r_byte_idx <= '0;
         r_word     <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_din      <= '0;
         r_cpu_rst  <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_xfer) begin
                  if (w_too_big) begin
                     r_state <= ST_ERROR;
                     r_err   <= 1'b1;
                  end else if (s_data == 8'd0) begin
                     r_state <= ST_CHECK;
                  end else begin
                     r_count    <= s_data;
                     r_byte_idx <= '0;
                     r_word_idx <= '0;
                     r_csum     <= '0;
                     r_state    <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (w_xfer) begin
                  r_csum     <= r_csum ^ s_data;
                  r_word     <= w_word;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3) begin
                     r_we       <= 1'b1;
                     r_addr     <= ADDR_W'(r_word_idx);
                     r_din      <= w_word;
                     r_word_idx <= w_word_next;
                     if (w_word_next == r_count) begin
                        r_state <= ST_CHECK;
                     end
                  end
               end
            end
            ST_CHECK: begin
               if (w_xfer) begin
                  if (s_data == r_csum) begin
                     r_state   <= ST_DONE;
                     r_done    <= 1'b1;
                     r_cpu_rst <= 1'b0;
                  end else begin
                     r_state <= ST_ERROR;
                     r_err   <= 1'b1;
                  end
               end
            end
            ST_DONE, ST_ERROR: begin
               if (reload) begin
                  r_state    <= ST_IDLE;
                  r_cpu_rst  <= 1'b1;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_count    <= '0;
                  r_csum     <= '0;
                  r_word_idx <= '0;
                  r_byte_idx <= '0;
                  r_word     <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign s_ready = w_ready;
   assign im_we   = r_we;
   assign im_addr = r_addr;
   assign im_din  = r_din;
   assign cpu_rst = r_cpu_rst;
   assign done    = r_done;
   assign err     = r_err;

endmodule

// File: doc/im_boot_loader.md
Name: im_boot_loader

Overview:
- Upstream feeder for the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the IM write port at consecutive addresses from 0.
- Verifies a trailing XOR checksum and holds the processor in reset until a good image is loaded.

Parameters:
- ADDR_W, 7, IM word-address width.
- DATA_W, 32, IM word width; fixed at 4 bytes, other values unsupported.
- DEPTH, 128, max words loadable (≤ 2^ADDR_W).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle pulse; restarts loading from DONE or ERROR.
- im_we  out  1  IM write enable, one-cycle pulse per word.
- im_addr  out  ADDR_W  IM write address.
- im_din  out  DATA_W  IM write data.
- cpu_rst  out  1  processor reset; high until image is verified.
- done  out  1  image loaded and checksum good.
- err  out  1  load failed (bad count or checksum).

Behaviour:
- Byte transfer occurs on a clk edge where s_valid && s_ready.
- s_ready=1 in IDLE, LOAD and CHECK; s_ready=0 in DONE and ERROR.
- Reset (async): state=IDLE; im_we=0; im_addr=0; im_din=0; cpu_rst=1; done=0; err=0. Byte counter, word counter and checksum are all cleared.
- IDLE: the first accepted byte is count N.
  - N>DEPTH → ERROR.
  - N=0 → CHECK.
  - Otherwise store N, clear counters → LOAD.
- LOAD: each accepted byte is placed at lane byte_idx; byte 0 is bits [7:0], byte 3 is bits [31:24].
  - Each data byte is XORed into the checksum (initial value 0x00; the count byte is excluded).
  - On acceptance of the 4th byte of a word, the next cycle drives im_we=1 for exactly one cycle, with im_din = the assembled word and im_addr = word index.
  - Word index starts at 0; it increments after each write and does not wrap because N≤DEPTH.
  - After the write of word N-1 → CHECK. The next byte may be accepted in the same cycle the write pulse is driven; no bubble is required.
- CHECK: the next accepted byte is compared to the running checksum.
  - Equal → DONE.
  - Unequal → ERROR.
- DONE: done=1 and cpu_rst=0, both registered and asserted the cycle after the checksum byte is accepted. im_addr and im_din hold their last values; im_we=0.
- ERROR: err=1, cpu_rst=1. IM contents written so far are left as they are.
- reload in DONE or ERROR → IDLE next cycle: cpu_rst=1, done=0, err=0, counters and checksum cleared. reload is ignored in IDLE, LOAD and CHECK.
- s_valid with s_ready=0 is ignored; no byte is consumed.
- An idle gap (s_valid low) at any point pauses the FSM with all state held.
- rst asserted mid-LOAD aborts immediately: the partial word is discarded and no im_we pulse is issued.
- im_we is never high in IDLE, CHECK, DONE or ERROR, apart from the single trailing write pulse driven in the first CHECK cycle.

Test Plan:
- Stream 02, 78 56 34 12, EF BE AD DE, checksum (XOR of the 8 data bytes) → writes 0x12345678 @0 and 0xDEADBEEF @1, then done=1, cpu_rst=0 one cycle after the checksum byte.
- Same stream with the checksum byte flipped → both words written; err=1, cpu_rst=1, done=0, s_ready=0; then a reload pulse → IDLE with s_ready=1.
- Count 0x81 (129 > DEPTH) → ERROR with no im_we pulses. Count 0x00 followed by checksum 00 → DONE.
- Full image N=128 with s_valid held high every cycle → 128 back-to-back writes at addresses 0..127, no dropped bytes, done asserted.
- Random s_valid gaps during LOAD → identical writes and addresses to the gapless run.
- rst asserted after 2 bytes of word 3 → all outputs return to reset values, no write at addr 3. The image is then restreamed and loads correctly.
